operand_collector: RTL and testbench

OPERAND_COLLECTOR -- requirements
Module: operand_collector

---
 rtl/operand_pkg.sv | 35 +++
 rtl/opcount_decode.sv | 14 +
 rtl/operand_collector.sv | 126 ++++++++++++
 tb/tb_operand_collector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared types, opcode range constants and operand-count decode for the operand collector.
package operand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Opcode ranges, inclusive
    localparam int unsigned TWO_OP_LO   = 32'h04;  // 00100
    localparam int unsigned TWO_OP_HI   = 32'h0C;  // 01100
    localparam int unsigned ONE_OP_LO   = 32'h0D;  // 01101
    localparam int unsigned ONE_OP_HI   = 32'h13;  // 10011
    localparam int unsigned ONE_OP_EXCL = 32'h0E;  // 01110 has no operands
    localparam int unsigned THREE_OP_LO = 32'h14;  // 10100
    localparam int unsigned THREE_OP_HI = 32'h17;  // 10111

    // Number of operands an opcode needs, capped at the available slot count
    function automatic logic [2:0] decode_op_count(input int unsigned opc,
                                                   input int unsigned max_ops);
        int unsigned n;
        n = 0;
        if (opc >= TWO_OP_LO && opc <= TWO_OP_HI)
            n = 2;
        else if (opc >= ONE_OP_LO && opc <= ONE_OP_HI && opc != ONE_OP_EXCL)
            n = 1;
        else if (opc >= THREE_OP_LO && opc <= THREE_OP_HI)
            n = 3;
        if (n > max_ops)
            n = max_ops;
        return 3'(n);
    endfunction

endpackage

// File: rtl/opcount_decode.sv
// Combinational opcode -> operand-count decoder, saturated at MAX_OPS.
module opcount_decode
    import operand_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MAX_OPS = 3
) (
    input  logic [OP_W-1:0] opcode_i,
    output logic [2:0]      count_o
);

    assign count_o = decode_op_count(32'(opcode_i), MAX_OPS);

endmodule

// File: rtl/operand_collector.sv
// Operand collector: latches an opcode, gathers its operands one per cycle
// and holds the completed bundle until the consumer accepts it.
module operand_collector
    import operand_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 5,
    parameter int MAX_OPS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [OP_W-1:0]           opcode,
    input  logic                      load,
    input  logic [DATA_W-1:0]         din,
    input  logic                      flush,
    input  logic                      ops_ready,
    output logic [MAX_OPS*DATA_W-1:0] operands,
    output logic [2:0]                op_count,
    output logic                      ops_valid,
    output logic                      busy
);

    // Index only needs to address MAX_OPS slots
    localparam int IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;

    state_t             state_q;
    logic [IDX_W-1:0]   index_q;
    logic [2:0]         op_count_q;
    logic [DATA_W-1:0]  slot_q [MAX_OPS];
    logic               ops_valid_q;
    logic               busy_q;

    logic [2:0]         op_count_d;
    logic               accept_start;
    logic               last_load;

    opcount_decode #(
        .OP_W    (OP_W),
        .MAX_OPS (MAX_OPS)
    ) u_decode (
        .opcode_i (opcode),
        .count_o  (op_count_d)
    );

    // A new instruction is taken in IDLE, or in DONE when the bundle is consumed the same cycle
    assign accept_start = start && ((state_q == ST_IDLE) ||
                                    (state_q == ST_DONE && ops_ready));

    // The load landing in slot op_count-1 completes the bundle
    assign last_load = (index_q == IDX_W'(op_count_q - 3'd1));

    // Control FSM with slot storage and registered status outputs
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            op_count_q  <= '0;
            ops_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            // NOTE: the slots are a handful of flops, not a RAM, so resetting
            // them is cheap and gives the required all-zero operands after reset.
            for (int k = 0; k < MAX_OPS; k++)
                slot_q[k] <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            op_count_q  <= '0;
            ops_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < MAX_OPS; k++)
                slot_q[k] <= '0;
        end else if (accept_start) begin
            index_q    <= '0;
            op_count_q <= op_count_d;
            for (int k = 0; k < MAX_OPS; k++)
                slot_q[k] <= '0;
            if (op_count_d != 3'd0) begin
                state_q     <= ST_COLLECT;
                busy_q      <= 1'b1;
                ops_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_DONE;
                busy_q      <= 1'b0;
                ops_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (load) begin
                        slot_q[index_q] <= din;
                        if (last_load) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            ops_valid_q <= 1'b1;
                        end else begin
                            index_q <= index_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ops_ready) begin
                        state_q     <= ST_IDLE;
                        ops_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pack the slots onto the output bus, slot k at bits [k*DATA_W +: DATA_W]
    always_comb begin
        operands = '0;
        for (int k = 0; k < MAX_OPS; k++)
            operands[k*DATA_W +: DATA_W] = slot_q[k];
    end

    assign op_count  = op_count_q;
    assign ops_valid = ops_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed vector table, hand-written
// async-reset and MAX_OPS=2 sequences, and randomized traffic against a model.
module tb_operand_collector;

    logic        clk;
    logic        rst;
    logic        start, load, flush, ops_ready;
    logic [4:0]  opcode;
    logic [7:0]  din;
    logic [23:0] operands;
    logic [2:0]  op_count;
    logic        ops_valid, busy;

    logic        s2_start, s2_load, s2_flush, s2_ready;
    logic [4:0]  s2_opcode;
    logic [7:0]  s2_din;
    logic [15:0] s2_operands;
    logic [2:0]  s2_op_count;
    logic        s2_valid, s2_busy;

    int checks = 0;
    int errors = 0;

    operand_collector #(.DATA_W(8), .OP_W(5), .MAX_OPS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .load      (load),
        .din       (din),
        .flush     (flush),
        .ops_ready (ops_ready),
        .operands  (operands),
        .op_count  (op_count),
        .ops_valid (ops_valid),
        .busy      (busy)
    );

    operand_collector #(.DATA_W(8), .OP_W(5), .MAX_OPS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (s2_start),
        .opcode    (s2_opcode),
        .load      (s2_load),
        .din       (s2_din),
        .flush     (s2_flush),
        .ops_ready (s2_ready),
        .operands  (s2_operands),
        .op_count  (s2_op_count),
        .ops_valid (s2_valid),
        .busy      (s2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic [4:0]  opc;
        logic        ld;
        logic [7:0]  d;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic        e_busy;
        logic [2:0]  e_cnt;
        logic [23:0] e_ops;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [4:0] opc, input logic ld,
                                input logic [7:0] d, input logic fl, input logic rdy,
                                input logic ev, input logic eb, input logic [2:0] ec,
                                input logic [23:0] eo);
        vec_t v;
        v.st = st; v.opc = opc; v.ld = ld; v.d = d; v.fl = fl; v.rdy = rdy;
        v.e_valid = ev; v.e_busy = eb; v.e_cnt = ec; v.e_ops = eo;
        return v;
    endfunction

    task automatic drive(input logic st, input logic [4:0] opc, input logic ld,
                         input logic [7:0] d, input logic fl, input logic rdy);
        start = st; opcode = opc; load = ld; din = d; flush = fl; ops_ready = rdy;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic eb,
                              input logic [2:0] ec, input logic [23:0] eo);
        check({tag, ".ops_valid"}, 32'(ops_valid), 32'(ev));
        check({tag, ".busy"},      32'(busy),      32'(eb));
        check({tag, ".op_count"},  32'(op_count),  32'(ec));
        check({tag, ".operands"},  32'(operands),  32'(eo));
    endtask

    // ---------------- behavioural reference model ----------------
    // The model tracks the instruction as "collecting/complete" plus a queue of
    // operands gathered so far; slot contents are derived from that queue.
    bit         m_collecting, m_complete;
    int         m_need;
    logic [7:0] m_got[$];

    function automatic int spec_count(input logic [4:0] opc, input int max_ops);
        int n;
        case (opc) inside
            5'b01110:          n = 0;
            [5'b00100:5'b01100]: n = 2;
            [5'b01101:5'b10011]: n = 1;
            [5'b10100:5'b10111]: n = 3;
            default:           n = 0;
        endcase
        return (n > max_ops) ? max_ops : n;
    endfunction

    task automatic model_reset();
        m_collecting = 0; m_complete = 0; m_need = 0; m_got.delete();
    endtask

    task automatic model_step(input logic st, input logic [4:0] opc, input logic ld,
                              input logic [7:0] d, input logic fl, input logic rdy);
        bit free;
        free = (!m_collecting && !m_complete) || (m_complete && rdy);
        if (fl) begin
            model_reset();
        end else if (free && st) begin
            m_need = spec_count(opc, 3);
            m_got.delete();
            m_collecting = (m_need > 0);
            m_complete   = (m_need == 0);
        end else if (m_complete && rdy) begin
            m_complete = 0;   // bundle consumed; slots keep their contents
        end else if (m_collecting && ld) begin
            m_got.push_back(d);
            if (m_got.size() == m_need) begin
                m_collecting = 0;
                m_complete   = 1;
            end
        end
    endtask

    function automatic logic [23:0] model_operands();
        logic [23:0] r;
        r = '0;
        foreach (m_got[i]) r[i*8 +: 8] = m_got[i];
        return r;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        drive(0, 5'h0, 0, 8'h0, 0, 0);
        s2_start = 0; s2_opcode = '0; s2_load = 0; s2_din = '0; s2_flush = 0; s2_ready = 0;

        // Reset state
        #2 rst = 1'b1;
        #10;
        check_outs("reset", 0, 0, 3'd0, 24'h0);
        rst = 1'b0;

        // Table: st opc ld din fl rdy | valid busy cnt operands
        vecs.push_back(mk(1, 5'h05, 0, 8'h00, 0, 0,  0, 1, 2, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'hA5, 0, 0,  0, 1, 2, 24'h0000A5));
        vecs.push_back(mk(0, 5'h00, 1, 8'h3C, 0, 0,  1, 0, 2, 24'h003CA5));
        vecs.push_back(mk(0, 5'h00, 1, 8'hEE, 0, 0,  1, 0, 2, 24'h003CA5));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 0, 1,  0, 0, 2, 24'h003CA5));
        vecs.push_back(mk(0, 5'h00, 1, 8'h55, 0, 0,  0, 0, 2, 24'h003CA5));
        vecs.push_back(mk(1, 5'h0E, 0, 8'h00, 0, 0,  1, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'h77, 0, 0,  1, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 5'h14, 0, 8'h00, 0, 1,  0, 1, 3, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'h11, 0, 0,  0, 1, 3, 24'h000011));
        vecs.push_back(mk(1, 5'h05, 0, 8'h00, 0, 0,  0, 1, 3, 24'h000011));
        vecs.push_back(mk(0, 5'h00, 1, 8'h22, 0, 0,  0, 1, 3, 24'h002211));
        vecs.push_back(mk(0, 5'h00, 1, 8'h33, 0, 0,  1, 0, 3, 24'h332211));
        vecs.push_back(mk(0, 5'h00, 1, 8'h99, 0, 0,  1, 0, 3, 24'h332211));
        vecs.push_back(mk(1, 5'h05, 0, 8'h00, 0, 0,  1, 0, 3, 24'h332211));
        vecs.push_back(mk(0, 5'h00, 1, 8'h98, 0, 0,  1, 0, 3, 24'h332211));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 0, 0,  1, 0, 3, 24'h332211));
        vecs.push_back(mk(1, 5'h0D, 0, 8'h00, 0, 1,  0, 1, 1, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'h5A, 0, 0,  1, 0, 1, 24'h00005A));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 0, 1,  0, 0, 1, 24'h00005A));
        vecs.push_back(mk(1, 5'h1F, 0, 8'h00, 0, 0,  1, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 0, 1,  0, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 5'h04, 0, 8'h00, 0, 0,  0, 1, 2, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'h9E, 0, 0,  0, 1, 2, 24'h00009E));
        vecs.push_back(mk(0, 5'h00, 1, 8'h44, 1, 0,  0, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 0, 0,  0, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 5'h0C, 0, 8'h00, 0, 0,  0, 1, 2, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 0, 8'h00, 1, 0,  0, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 5'h17, 0, 8'h00, 1, 0,  0, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 5'h13, 0, 8'h00, 0, 0,  0, 1, 1, 24'h000000));
        vecs.push_back(mk(0, 5'h00, 1, 8'hF0, 0, 0,  1, 0, 1, 24'h0000F0));
        vecs.push_back(mk(1, 5'h05, 0, 8'h00, 1, 1,  0, 0, 0, 24'h000000));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].opc, vecs[i].ld, vecs[i].d, vecs[i].fl, vecs[i].rdy);
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_busy,
                       vecs[i].e_cnt, vecs[i].e_ops);
        end

        // Async reset in the middle of a collection
        drive(1, 5'h04, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        drive(0, 5'h00, 1, 8'h12, 0, 0);
        @(posedge clk); #1;
        drive(0, 5'h00, 0, 8'h00, 0, 0);
        check_outs("pre_rst", 0, 1, 3'd2, 24'h000012);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 3'd0, 24'h000000);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        drive(1, 5'h0F, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        check_outs("post_rst_start", 0, 1, 3'd1, 24'h000000);
        drive(0, 5'h00, 1, 8'hC3, 0, 0);
        @(posedge clk); #1;
        check_outs("post_rst_load", 1, 0, 3'd1, 24'h0000C3);
        drive(0, 5'h00, 0, 8'h00, 1, 0);
        @(posedge clk); #1;
        check_outs("pre_random_flush", 0, 0, 3'd0, 24'h000000);

        // Randomized traffic against the reference model
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic st, ld, fl, rdy;
            logic [4:0] opc;
            logic [7:0] d;
            st  = ($urandom_range(0, 2) == 0);
            opc = 5'($urandom_range(0, 31));
            ld  = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom_range(0, 255));
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            drive(st, opc, ld, d, fl, rdy);
            model_step(st, opc, ld, d, fl, rdy);
            @(posedge clk); #1;
            check_outs($sformatf("rand%0d", n), m_complete, m_collecting,
                       3'(m_need), model_operands());
        end
        drive(0, 5'h00, 0, 8'h00, 0, 0);

        // MAX_OPS=2 build: three-operand opcode saturates to two slots
        s2_start = 1; s2_opcode = 5'h14;
        @(posedge clk); #1;
        s2_start = 0;
        check("m2.op_count", 32'(s2_op_count), 32'd2);
        check("m2.busy",     32'(s2_busy),     32'd1);
        s2_load = 1; s2_din = 8'hAA;
        @(posedge clk); #1;
        check("m2.operands1", 32'(s2_operands), 32'h00AA);
        check("m2.valid1",    32'(s2_valid),    32'd0);
        s2_din = 8'hBB;
        @(posedge clk); #1;
        check("m2.operands2", 32'(s2_operands), 32'hBBAA);
        check("m2.valid2",    32'(s2_valid),    32'd1);
        check("m2.busy2",     32'(s2_busy),     32'd0);
        s2_din = 8'hCC;
        @(posedge clk); #1;
        s2_load = 0;
        check("m2.operands3", 32'(s2_operands), 32'hBBAA);
        check("m2.valid3",    32'(s2_valid),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
